// File: rtl/nx_node_mem_arbiter_pkg.sv
// Shared types and constants for the node data-RAM arbiter.
// Optional forwarding is selected by NX_MEM_ARB_FWD_EN (see nx_node_mem_arbiter).
package nx_node_mem_arbiter_pkg;

   localparam int RAM_ADDR_W             = 10;
   localparam int RAM_DATA_W             = 32;
   localparam int NODE_MEM_WR_FIFO_DEPTH = 4;

   typedef struct packed {
      logic [9:0] row;
      logic [1:0] slot;
      logic [7:0] data;
   } node_mem_write_t;

   function automatic logic [RAM_DATA_W-1:0] lane_strobe(input logic [1:0] slot);
      return 32'h0000_00FF << {slot, 3'd0};
   endfunction

   function automatic logic [RAM_DATA_W-1:0] replicate_byte(input logic [7:0] data);
      return {4{data}};
   endfunction

endpackage

// File: rtl/nx_node_wr_fifo.sv
// Inbound byte-write queue. With NX_MEM_ARB_FWD_EN defined it also exposes
// its storage and head pointer so the reader can search queued writes.
module nx_node_wr_fifo
   import nx_node_mem_arbiter_pkg::*;
#(
   parameter  int FIFO_DEPTH = NODE_MEM_WR_FIFO_DEPTH,
   localparam int PTR_W      = $clog2(FIFO_DEPTH),
   localparam int LVL_W      = PTR_W + 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_push,
   input  node_mem_write_t i_push_data,
   input  logic            i_pop,
   output node_mem_write_t o_head,
   output logic [LVL_W-1:0] o_level,
   output logic            o_empty
`ifdef NX_MEM_ARB_FWD_EN
   ,
   output logic [PTR_W-1:0] o_head_ptr,
   output node_mem_write_t o_entries [FIFO_DEPTH]
`endif
);

   node_mem_write_t  mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [LVL_W-1:0] level_r;
   logic             pop_s;

   assign pop_s   = i_pop && (level_r != '0);
   assign o_head  = mem_r[rd_ptr_r];
   assign o_level = level_r;
   assign o_empty = (level_r == '0);

`ifdef NX_MEM_ARB_FWD_EN
   assign o_head_ptr = rd_ptr_r;
   assign o_entries  = mem_r;
`endif

   // storage, pointers and occupancy; pointers wrap naturally at the power-of-two depth
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
      end else begin
         if (i_push) begin
            mem_r[wr_ptr_r] <= i_push_data;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({i_push, pop_s})
            2'b10:   level_r <= level_r + LVL_W'(1);
            2'b01:   level_r <= level_r - LVL_W'(1);
            default: level_r <= level_r;
         endcase
      end
   end

endmodule

// File: rtl/nx_node_mem_arbiter.sv
// Data-RAM arbiter: core has absolute priority, inbound byte writes drain in idle cycles.
// Define NX_MEM_ARB_FWD_EN to forward queued writes into core read data.
module nx_node_mem_arbiter
   import nx_node_mem_arbiter_pkg::*;
#(
   parameter  int FIFO_DEPTH = NODE_MEM_WR_FIFO_DEPTH,
   localparam int PTR_W      = $clog2(FIFO_DEPTH),
   localparam int LVL_W      = PTR_W + 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [RAM_ADDR_W-1:0] i_core_addr,
   input  logic [RAM_DATA_W-1:0] i_core_wr_data,
   input  logic [RAM_DATA_W-1:0] i_core_wr_strb,
   input  logic                  i_core_rd_en,
   output logic [RAM_DATA_W-1:0] o_core_rd_data,
   input  logic [RAM_ADDR_W-1:0] i_in_row,
   input  logic [1:0]            i_in_slot,
   input  logic [7:0]            i_in_data,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   output logic [RAM_ADDR_W-1:0] o_ram_addr,
   output logic [RAM_DATA_W-1:0] o_ram_wr_data,
   output logic [RAM_DATA_W-1:0] o_ram_wr_strb,
   output logic                  o_ram_rd_en,
   input  logic [RAM_DATA_W-1:0] i_ram_rd_data,
   output logic                  o_pending,
   output logic [LVL_W-1:0]      o_level
);

   logic            core_act_s;
   logic            push_s;
   logic            pop_s;
   logic            empty_s;
   logic            rd_valid_r;
   node_mem_write_t head_s;
   node_mem_write_t push_data_s;
   logic [LVL_W-1:0] level_s;

   assign core_act_s  = i_core_rd_en || (|i_core_wr_strb);
   assign pop_s       = !core_act_s && !empty_s;
   // ready never looks at this cycle's pop; held low throughout reset
   assign o_in_ready  = i_rst && (level_s < LVL_W'(FIFO_DEPTH));
   assign push_s      = i_in_valid && o_in_ready;
   assign push_data_s = '{row: i_in_row, slot: i_in_slot, data: i_in_data};
   assign o_pending   = !empty_s;
   assign o_level     = level_s;

`ifdef NX_MEM_ARB_FWD_EN
   logic [PTR_W-1:0] head_ptr_s;
   node_mem_write_t  entries_s [FIFO_DEPTH];
   logic [31:0]      fwd_bytes_s;
   logic [3:0]       fwd_mask_s;
   logic [31:0]      fwd_bytes_r;
   logic [3:0]       fwd_mask_r;
`endif

   nx_node_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_wr_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (push_s),
      .i_push_data (push_data_s),
      .i_pop       (pop_s),
      .o_head      (head_s),
      .o_level     (level_s),
      .o_empty     (empty_s)
`ifdef NX_MEM_ARB_FWD_EN
      ,
      .o_head_ptr  (head_ptr_s),
      .o_entries   (entries_s)
`endif
   );

   // RAM port mux: core passthrough, else drain head entry, else quiet
   always_comb begin
      o_ram_addr    = '0;
      o_ram_wr_data = '0;
      o_ram_wr_strb = '0;
      o_ram_rd_en   = 1'b0;
      if (core_act_s) begin
         o_ram_addr    = i_core_addr;
         o_ram_wr_data = i_core_wr_data;
         o_ram_wr_strb = i_core_wr_strb;
         o_ram_rd_en   = i_core_rd_en;
      end else if (pop_s) begin
         o_ram_addr    = head_s.row;
         o_ram_wr_data = replicate_byte(head_s.data);
         o_ram_wr_strb = lane_strobe(head_s.slot);
      end else begin
         o_ram_addr    = '0;
      end
   end

`ifdef NX_MEM_ARB_FWD_EN
   // merge queued writes to the read row, oldest first so newer bytes win
   always_comb begin : fwd_merge
      logic [PTR_W-1:0] idx;
      fwd_bytes_s = '0;
      fwd_mask_s  = '0;
      idx         = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         idx = head_ptr_s + PTR_W'(i);
         if ((LVL_W'(i) < level_s) && (entries_s[idx].row == i_core_addr)) begin
            fwd_mask_s[entries_s[idx].slot]                     = 1'b1;
            fwd_bytes_s[{entries_s[idx].slot, 3'd0} +: 8]       = entries_s[idx].data;
         end else begin
            fwd_mask_s = fwd_mask_s;
         end
      end
   end

   // read-valid and forwarding registers
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         rd_valid_r  <= 1'b0;
         fwd_bytes_r <= '0;
         fwd_mask_r  <= '0;
      end else begin
         rd_valid_r  <= i_core_rd_en;
         fwd_bytes_r <= i_core_rd_en ? fwd_bytes_s : 32'h0000_0000;
         fwd_mask_r  <= i_core_rd_en ? fwd_mask_s  : 4'h0;
      end
   end

   // lane-wise select between forwarded bytes and RAM data
   always_comb begin
      o_core_rd_data = '0;
      if (rd_valid_r) begin
         for (int l = 0; l < 4; l++) begin
            o_core_rd_data[l*8 +: 8] = fwd_mask_r[l] ? fwd_bytes_r[l*8 +: 8]
                                                     : i_ram_rd_data[l*8 +: 8];
         end
      end else begin
         o_core_rd_data = '0;
      end
   end
`else
   // read-valid register
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         rd_valid_r <= 1'b0;
      end else begin
         rd_valid_r <= i_core_rd_en;
      end
   end

   // raw RAM data, zero outside a read return cycle
   always_comb begin
      o_core_rd_data = '0;
      if (rd_valid_r) begin
         o_core_rd_data = i_ram_rd_data;
      end else begin
         o_core_rd_data = '0;
      end
   end
`endif

endmodule

// File: tb/tb_nx_node_mem_arbiter.sv
// Directed bench for nx_node_mem_arbiter with a behavioural 1024x32 RAM.
// Expectations for forwarded reads follow NX_MEM_ARB_FWD_EN.
module tb_nx_node_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [9:0]  core_addr;
   logic [31:0] core_wr_data;
   logic [31:0] core_wr_strb;
   logic        core_rd_en;
   logic [31:0] core_rd_data;
   logic [9:0]  in_row;
   logic [1:0]  in_slot;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [9:0]  ram_addr;
   logic [31:0] ram_wr_data;
   logic [31:0] ram_wr_strb;
   logic        ram_rd_en;
   logic [31:0] ram_rd_data = 32'h0;
   logic        pending;
   logic [2:0]  level;

   int total = 0;
   int fails = 0;

   logic [31:0] mem [1024];
   bit          loaded = 1'b0;

   // drain-order expectations for the core-priority section
   logic [9:0]  d_row  [5] = '{10'd20, 10'd21, 10'd22, 10'd23, 10'd24};
   logic [1:0]  d_slot [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic [7:0]  d_data [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
   logic [31:0] d_strb [5] = '{32'h0000_00FF, 32'h0000_FF00, 32'h00FF_0000, 32'hFF00_0000, 32'h0000_00FF};
   logic [31:0] d_wd   [5] = '{32'h1010_1010, 32'h1111_1111, 32'h1212_1212, 32'h1313_1313, 32'h1414_1414};
   logic [2:0]  d_lvl  [5] = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd1};

`ifdef NX_MEM_ARB_FWD_EN
   localparam logic [31:0] EXP_FWD_A = 32'h1122_33AA;
   localparam logic [31:0] EXP_FWD_B = 32'h1122_33BB;
`else
   localparam logic [31:0] EXP_FWD_A = 32'h1122_3344;
   localparam logic [31:0] EXP_FWD_B = 32'h1122_3344;
`endif

   always #5 clk = ~clk;

   nx_node_mem_arbiter #(.FIFO_DEPTH(4)) dut (
      .i_clk          (clk),
      .i_rst          (rst_n),
      .i_core_addr    (core_addr),
      .i_core_wr_data (core_wr_data),
      .i_core_wr_strb (core_wr_strb),
      .i_core_rd_en   (core_rd_en),
      .o_core_rd_data (core_rd_data),
      .i_in_row       (in_row),
      .i_in_slot      (in_slot),
      .i_in_data      (in_data),
      .i_in_valid     (in_valid),
      .o_in_ready     (in_ready),
      .o_ram_addr     (ram_addr),
      .o_ram_wr_data  (ram_wr_data),
      .o_ram_wr_strb  (ram_wr_strb),
      .o_ram_rd_en    (ram_rd_en),
      .i_ram_rd_data  (ram_rd_data),
      .o_pending      (pending),
      .o_level        (level)
   );

   // behavioural RAM: per-bit strobed write, 1-cycle read latency
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
         mem[7] <= 32'hDEAD_BEEF;
         mem[9] <= 32'h1122_3344;
         mem[3] <= 32'h5566_7788;
         loaded <= 1'b1;
      end else begin
         if (|ram_wr_strb) mem[ram_addr] <= (mem[ram_addr] & ~ram_wr_strb) | (ram_wr_data & ram_wr_strb);
         if (ram_rd_en) ram_rd_data <= mem[ram_addr];
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic core_idle();
      core_addr = 10'd0; core_wr_data = 32'h0; core_wr_strb = 32'h0; core_rd_en = 1'b0;
   endtask

   task automatic push(input logic v, input logic [9:0] r, input logic [1:0] s, input logic [7:0] d);
      in_valid = v; in_row = r; in_slot = s; in_data = d;
   endtask

   initial begin
      core_idle();
      push(1'b0, 10'd0, 2'd0, 8'h00);
      #1 rst_n = 1'b0;
      #1;
      check("rst_ready",   32'(in_ready), 32'h0);
      check("rst_level",   32'(level), 32'h0);
      check("rst_pending", 32'(pending), 32'h0);
      check("rst_strb",    ram_wr_strb, 32'h0);
      check("rst_addr",    32'(ram_addr), 32'h0);
      check("rst_rd_en",   32'(ram_rd_en), 32'h0);
      check("rst_rd_data", core_rd_data, 32'h0);
      cyc(); cyc();
      @(negedge clk) rst_n = 1'b1;
      #1 check("rel_ready", 32'(in_ready), 32'h1);

      // idle drain
      cyc();
      push(1'b1, 10'd5, 2'd2, 8'hA5);
      #1;
      check("idle_ready", 32'(in_ready), 32'h1);
      check("idle_nowr",  ram_wr_strb, 32'h0);
      cyc();
      push(1'b0, 10'd0, 2'd0, 8'h00);
      #1;
      check("idle_lvl1",  32'(level), 32'h1);
      check("idle_pend",  32'(pending), 32'h1);
      check("idle_addr",  32'(ram_addr), 32'd5);
      check("idle_strb",  ram_wr_strb, 32'h00FF_0000);
      check("idle_wd",    ram_wr_data, 32'hA5A5_A5A5);
      check("idle_rden",  32'(ram_rd_en), 32'h0);
      cyc();
      #1;
      check("idle_lvl0",  32'(level), 32'h0);
      check("idle_quiet", ram_wr_strb, 32'h0);

      // core priority: reads of row 7 for six cycles while five pushes are offered
      for (int k = 0; k < 6; k++) begin
         core_rd_en = 1'b1; core_addr = 10'd7;
         push(1'b1, d_row[(k < 4) ? k : 4], d_slot[(k < 4) ? k : 4], d_data[(k < 4) ? k : 4]);
         #1;
         check("pri_ready", 32'(in_ready), (k < 4) ? 32'h1 : 32'h0);
         check("pri_level", 32'(level), (k < 4) ? 32'(k) : 32'd4);
         check("pri_nowr",  ram_wr_strb, 32'h0);
         check("pri_addr",  32'(ram_addr), 32'd7);
         if (k > 0) check("pri_rdata", core_rd_data, 32'hDEAD_BEEF);
         cyc();
      end
      // drain in order; entry 4 waits while full, then enters
      for (int j = 0; j < 5; j++) begin
         core_idle();
         if (j <= 1) push(1'b1, d_row[4], d_slot[4], d_data[4]);
         else        push(1'b0, 10'd0, 2'd0, 8'h00);
         #1;
         if (j == 0) check("full_ready0", 32'(in_ready), 32'h0);
         if (j == 1) check("full_ready1", 32'(in_ready), 32'h1);
         check("drn_level", 32'(level), 32'(d_lvl[j]));
         check("drn_addr",  32'(ram_addr), 32'(d_row[j]));
         check("drn_strb",  ram_wr_strb, d_strb[j]);
         check("drn_wd",    ram_wr_data, d_wd[j]);
         cyc();
      end
      #1;
      check("drn_empty", 32'(level), 32'h0);
      check("drn_quiet", ram_wr_strb, 32'h0);

      // forwarding of queued writes to row 9 (push in the read cycle is excluded)
      core_rd_en = 1'b1; core_addr = 10'd9;
      push(1'b1, 10'd9, 2'd0, 8'hAA);
      #1 check("fwd_none", core_rd_data, 32'h0);
      cyc();
      push(1'b1, 10'd9, 2'd0, 8'hBB);
      #1 check("fwd_same_cycle", core_rd_data, 32'h1122_3344);
      cyc();
      push(1'b0, 10'd0, 2'd0, 8'h00);
      #1 check("fwd_one", core_rd_data, EXP_FWD_A);
      cyc();
      core_idle();
      #1;
      check("fwd_two",    core_rd_data, EXP_FWD_B);
      check("fwd_drn_aa", ram_wr_data, 32'hAAAA_AAAA);
      check("fwd_drn_st", ram_wr_strb, 32'h0000_00FF);
      cyc();
      #1 check("fwd_drn_bb", ram_wr_data, 32'hBBBB_BBBB);
      cyc();
      core_rd_en = 1'b1; core_addr = 10'd9;
      cyc();
      core_idle();
      #1 check("fwd_ram9", core_rd_data, 32'h1122_33BB);

      // same-cycle push and read of row 3
      cyc();
      core_rd_en = 1'b1; core_addr = 10'd3;
      push(1'b1, 10'd3, 2'd1, 8'hCC);
      cyc();
      core_idle();
      push(1'b0, 10'd0, 2'd0, 8'h00);
      #1;
      check("sc_rdata", core_rd_data, 32'h5566_7788);
      check("sc_addr",  32'(ram_addr), 32'd3);
      check("sc_strb",  ram_wr_strb, 32'h0000_FF00);
      check("sc_wd",    ram_wr_data, 32'hCCCC_CCCC);
      cyc();
      core_rd_en = 1'b1; core_addr = 10'd3;
      cyc();
      core_idle();
      #1 check("sc_ram3", core_rd_data, 32'h5566_CC88);

      // reset with three writes queued
      for (int k = 0; k < 3; k++) begin
         core_rd_en = 1'b1; core_addr = 10'd0;
         push(1'b1, 10'(40 + k), 2'd0, 8'h77);
         cyc();
      end
      push(1'b0, 10'd0, 2'd0, 8'h00);
      #1 check("mr_level3", 32'(level), 32'd3);
      core_idle();
      rst_n = 1'b0;
      #1;
      check("mr_level", 32'(level), 32'h0);
      check("mr_pend",  32'(pending), 32'h0);
      check("mr_ready", 32'(in_ready), 32'h0);
      check("mr_strb",  ram_wr_strb, 32'h0);
      cyc();
      check("mr_strb2", ram_wr_strb, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      #1;
      check("mr_rel_ready", 32'(in_ready), 32'h1);
      check("mr_rel_level", 32'(level), 32'h0);
      check("mr_rel_strb",  ram_wr_strb, 32'h0);
      cyc();
      check("mr_post_strb", ram_wr_strb, 32'h0);
      core_rd_en = 1'b1; core_addr = 10'd40;
      cyc();
      core_idle();
      #1 check("mr_row40", core_rd_data, 32'h0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
